// File: rtl/hs_seq_pkg.sv
// ---------------------------------------------------------------------------
// hs_seq_pkg
// Shared definitions for the HS transmit sequencer.
//   seq_state_t       : sequencer state encoding
//   SYNC_BYTE         : leader byte sent between HS-zero and the payload
//   DEF_*_CYC         : default HS-prepare / HS-zero / HS-trail lengths
//   BYTE_COUNT_MAX    : saturation value of the optional payload counter
//   timer_load_value(): converts a cycle count into the down-counter preload
// ---------------------------------------------------------------------------
package hs_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREPARE,
      ST_ZERO,
      ST_SYNC,
      ST_DATA,
      ST_TRAIL,
      ST_EXIT
   } seq_state_t;

   localparam logic [7:0]  SYNC_BYTE       = 8'hB8;
   localparam int          DEF_PREPARE_CYC = 4;
   localparam int          DEF_ZERO_CYC    = 10;
   localparam int          DEF_TRAIL_CYC   = 6;
   localparam logic [15:0] BYTE_COUNT_MAX  = 16'hFFFF;

   // The timer counts the preload down to zero and the state moves on when it
   // reads zero, so a phase of N cycles needs a preload of N-1. A requested
   // length of 0 (or anything below 1) is stretched to a single cycle.
   function automatic logic [7:0] timer_load_value(input int cycles);
      if (cycles <= 1) begin
         return 8'd0;
      end
      return 8'(cycles - 1);
   endfunction

endpackage

// File: rtl/hs_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// hs_tx_sequencer_if
// Groups the PPI handshake and the lane-side outputs of the HS sequencer.
//   TxRequestHS  : HS transmit request from the protocol layer
//   TxDataHS[7:0]: payload byte, LSB transmitted first
//   TxReadyHS    : payload byte accepted on an edge where it is high with
//                  TxRequestHS
//   hs_byte[7:0] : registered byte towards the serializer / dual-edge stage
//   deff_en      : enable for the dual-edge output flip-flops
//   hs_drv_en    : HS differential driver enable
//   Stopstate    : lane is in the stop state (sequencer idle)
//   byte_count   : payload bytes of the current/last burst (only when the
//                  HS_SEQ_STATUS_EN macro is defined)
// Modports: master = protocol-layer side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface hs_tx_sequencer_if;

   logic        TxRequestHS;
   logic [7:0]  TxDataHS;
   logic        TxReadyHS;
   logic [7:0]  hs_byte;
   logic        deff_en;
   logic        hs_drv_en;
   logic        Stopstate;
`ifdef HS_SEQ_STATUS_EN
   logic [15:0] byte_count;
`endif

   modport master (
      output TxRequestHS,
      output TxDataHS,
      input  TxReadyHS,
      input  hs_byte,
      input  deff_en,
      input  hs_drv_en,
      input  Stopstate
`ifdef HS_SEQ_STATUS_EN
      , input byte_count
`endif
   );

   modport slave (
      input  TxRequestHS,
      input  TxDataHS,
      output TxReadyHS,
      output hs_byte,
      output deff_en,
      output hs_drv_en,
      output Stopstate
`ifdef HS_SEQ_STATUS_EN
      , output byte_count
`endif
   );

endinterface

// File: rtl/hs_seq_timer.sv
// ---------------------------------------------------------------------------
// hs_seq_timer
// 8-bit loadable down-counter that times the HS-prepare, HS-zero and HS-trail
// phases of the sequencer.
//   TxByteClkHS     : byte clock, rising edge
//   TxRst           : asynchronous active-high reset, clears the count
//   load            : preload the counter with load_value on this edge
//   load_value[7:0] : preload (phase length minus one)
//   done            : count has reached zero
// ---------------------------------------------------------------------------
module hs_seq_timer (
   input  logic       TxByteClkHS,
   input  logic       TxRst,
   input  logic       load,
   input  logic [7:0] load_value,
   output logic       done
);

   logic [7:0] count;

   // Load wins over counting so a phase can be armed on the same edge the
   // previous one finishes; once at zero the counter parks there.
   always_ff @(posedge TxByteClkHS or posedge TxRst) begin
      if (TxRst) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_value;
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign done = (count == 8'd0);

endmodule

// File: rtl/hs_tx_sequencer.sv
// ---------------------------------------------------------------------------
// hs_tx_sequencer
// MIPI-style HS transmit sequencer: walks a lane through
// IDLE -> PREPARE -> ZERO -> SYNC -> DATA -> TRAIL -> EXIT -> IDLE,
// producing the byte stream and driver enables for the serializer.
// Parameters:
//   PREPARE_CYC, ZERO_CYC, TRAIL_CYC : phase lengths in byte-clock cycles
//                                      (legal 1..255, 0 behaves as 1)
// Ports:
//   TxByteClkHS : sole clock, rising edge
//   TxRst       : asynchronous active-high reset
//   bus         : hs_tx_sequencer_if.slave (PPI handshake + lane outputs)
// Optional build macro:
//   HS_SEQ_STATUS_EN : adds bus.byte_count, the saturating count of payload
//                      bytes accepted in the current/last burst.
// All outputs come straight from flip-flops.
// ---------------------------------------------------------------------------
module hs_tx_sequencer
   import hs_seq_pkg::*;
#(
   parameter int PREPARE_CYC = DEF_PREPARE_CYC,
   parameter int ZERO_CYC    = DEF_ZERO_CYC,
   parameter int TRAIL_CYC   = DEF_TRAIL_CYC
) (
   input  logic             TxByteClkHS,
   input  logic             TxRst,
   hs_tx_sequencer_if.slave bus
);

   localparam logic [7:0] PREPARE_LOAD = timer_load_value(PREPARE_CYC);
   localparam logic [7:0] ZERO_LOAD    = timer_load_value(ZERO_CYC);
   localparam logic [7:0] TRAIL_LOAD   = timer_load_value(TRAIL_CYC);

   seq_state_t state_q;
   seq_state_t state_d;

   logic [7:0] hs_byte_q;
   logic [7:0] hs_byte_d;
   logic       deff_en_q;
   logic       deff_en_d;
   logic       hs_drv_en_q;
   logic       hs_drv_en_d;
   logic       ready_q;
   logic       ready_d;
   logic       stop_q;
   logic       stop_d;

   logic       timer_load;
   logic [7:0] timer_value;
   logic       timer_done;

   hs_seq_timer u_timer (
      .TxByteClkHS (TxByteClkHS),
      .TxRst       (TxRst),
      .load        (timer_load),
      .load_value  (timer_value),
      .done        (timer_done)
   );

   // State and every output are registered together, so the outputs seen in
   // a cycle always belong to the state held in that same cycle. Reset puts
   // the lane straight back into the stop state without waiting for a clock.
   always_ff @(posedge TxByteClkHS or posedge TxRst) begin
      if (TxRst) begin
         state_q     <= ST_IDLE;
         hs_byte_q   <= 8'h00;
         deff_en_q   <= 1'b0;
         hs_drv_en_q <= 1'b0;
         ready_q     <= 1'b0;
         stop_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         hs_byte_q   <= hs_byte_d;
         deff_en_q   <= deff_en_d;
         hs_drv_en_q <= hs_drv_en_d;
         ready_q     <= ready_d;
         stop_q      <= stop_d;
      end
   end

   // Next-state logic plus the output values for the state being entered.
   // TxReadyHS is already high during SYNC: the first payload byte is taken
   // on the edge that leaves SYNC, so it follows the sync byte on the wire
   // with no gap. An edge in SYNC or DATA with the request low ends the burst
   // without consuming a byte. The trail byte is the inverse of bit 7 of
   // whatever byte was last on the wire, captured on the edge entering TRAIL.
   // The request is ignored from TRAIL onwards and EXIT always falls back to
   // IDLE, so a request held high sees one stop-state cycle between bursts.
   always_comb begin
      state_d     = state_q;
      hs_byte_d   = hs_byte_q;
      deff_en_d   = 1'b0;
      hs_drv_en_d = 1'b0;
      ready_d     = 1'b0;
      stop_d      = 1'b0;
      timer_load  = 1'b0;
      timer_value = 8'd0;

      case (state_q)
         ST_IDLE: begin
            if (bus.TxRequestHS) begin
               state_d     = ST_PREPARE;
               timer_load  = 1'b1;
               timer_value = PREPARE_LOAD;
            end
         end
         ST_PREPARE: begin
            if (timer_done) begin
               state_d     = ST_ZERO;
               timer_load  = 1'b1;
               timer_value = ZERO_LOAD;
            end
         end
         ST_ZERO: begin
            if (timer_done) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC, ST_DATA: begin
            if (bus.TxRequestHS) begin
               state_d = ST_DATA;
            end else begin
               state_d     = ST_TRAIL;
               timer_load  = 1'b1;
               timer_value = TRAIL_LOAD;
            end
         end
         ST_TRAIL: begin
            if (timer_done) begin
               state_d = ST_EXIT;
            end
         end
         ST_EXIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_IDLE: begin
            hs_byte_d = 8'h00;
            stop_d    = 1'b1;
         end
         ST_PREPARE: begin
            hs_byte_d   = 8'h00;
            hs_drv_en_d = 1'b1;
         end
         ST_ZERO: begin
            hs_byte_d   = 8'h00;
            hs_drv_en_d = 1'b1;
            deff_en_d   = 1'b1;
         end
         ST_SYNC: begin
            hs_byte_d   = SYNC_BYTE;
            hs_drv_en_d = 1'b1;
            deff_en_d   = 1'b1;
            ready_d     = 1'b1;
         end
         ST_DATA: begin
            hs_byte_d   = bus.TxDataHS;
            hs_drv_en_d = 1'b1;
            deff_en_d   = 1'b1;
            ready_d     = 1'b1;
         end
         ST_TRAIL: begin
            if (state_q != ST_TRAIL) begin
               hs_byte_d = {8{~hs_byte_q[7]}};
            end
            hs_drv_en_d = 1'b1;
            deff_en_d   = 1'b1;
         end
         ST_EXIT: begin
            hs_byte_d = 8'h00;
         end
         default: begin
            hs_byte_d = 8'h00;
            stop_d    = 1'b1;
         end
      endcase
   end

   assign bus.TxReadyHS = ready_q;
   assign bus.hs_byte   = hs_byte_q;
   assign bus.deff_en   = deff_en_q;
   assign bus.hs_drv_en = hs_drv_en_q;
   assign bus.Stopstate = stop_q;

`ifdef HS_SEQ_STATUS_EN
   logic [15:0] byte_count_q;

   // Counts accepted payload bytes of the burst in flight. It restarts when
   // the sync byte goes out, sticks at all-ones on very long bursts and keeps
   // its value through EXIT and IDLE so software can read it afterwards.
   always_ff @(posedge TxByteClkHS or posedge TxRst) begin
      if (TxRst) begin
         byte_count_q <= 16'd0;
      end else if (state_q == ST_ZERO && state_d == ST_SYNC) begin
         byte_count_q <= 16'd0;
      end else if (ready_q && bus.TxRequestHS && byte_count_q != BYTE_COUNT_MAX) begin
         byte_count_q <= byte_count_q + 16'd1;
      end
   end

   assign bus.byte_count = byte_count_q;
`endif

endmodule
